// File: rtl/reg_shift_unit.sv
// Multi-cycle register-specified shifter (Rm shifted by Rs) for the EXE stage.
// Shifts up to STEP bits per cycle and produces the operand plus the shifter carry-out.
module reg_shift_unit #(
  parameter int unsigned STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] Val_Rm,
  input  logic [31:0] Val_Rs,
  input  logic [1:0]  shift_mode,
  input  logic        C_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        C_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {LSL, LSR, ASR, ROR} mode_t;

  localparam logic [5:0] STEP6 = 6'(STEP);

  state_t      state, state_nx;
  mode_t       mode, in_mode;
  logic [31:0] work, shifted;
  logic [5:0]  remaining, k, n_cap;
  logic [4:0]  c_idx;
  logic        shift_c, zero_c;
  logic [7:0]  amt;
  logic        unused_rs;

  assign amt       = Val_Rs[7:0];
  assign unused_rs = ^Val_Rs[31:8];
  assign in_mode   = mode_t'(shift_mode);

  always_comb begin
    n_cap = '0;
    if (in_mode == ROR) n_cap = {1'b0, amt[4:0]};
    else if (amt > 8'd32) n_cap = 6'd32;
    else n_cap = amt[5:0];
  end

  always_comb begin
    k       = (remaining < STEP6) ? remaining : STEP6;
    shifted = work;
    c_idx   = 5'(k - 6'd1);
    case (mode)
      LSL: begin
        shifted = work << k;
        c_idx   = 5'(6'd32 - k);
      end
      LSR: shifted = work >> k;
      ASR: shifted = 32'($signed(work) >>> k);
      ROR: shifted = (work >> k) | (work << (6'd32 - k));
      default: shifted = work;
    endcase
    shift_c = work[c_idx];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (n_cap == '0) ? DONE : SHIFT;
      SHIFT:   if (remaining <= STEP6) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE) && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mode      <= LSL;
      work      <= '0;
      remaining <= '0;
      zero_c    <= 1'b0;
      out       <= '0;
      C_out     <= 1'b0;
    end else begin
      state <= state_nx;
      if (flush) begin
        remaining <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            work      <= Val_Rm;
            mode      <= in_mode;
            remaining <= n_cap;
            zero_c    <= ((in_mode == LSL) || (in_mode == LSR)) && (amt > 8'd32);
            // n==0 covers amt==0 (carry passes through) and ROR by a multiple of 32
            if (n_cap == '0) begin
              out   <= Val_Rm;
              C_out <= (amt == '0) ? C_in : Val_Rm[31];
            end
          end
          SHIFT: begin
            work      <= shifted;
            remaining <= remaining - k;
            if (remaining <= STEP6) begin
              out   <= shifted;
              C_out <= zero_c ? 1'b0 : shift_c;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_shift_unit.sv
// Scoreboard bench for reg_shift_unit (STEP=4): directed vectors push expected
// results; a negedge monitor pops and checks them whenever done is presented.
module tb_reg_shift_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush, C_in;
  logic [31:0] Val_Rm, Val_Rs;
  logic [1:0]  shift_mode;
  logic        busy, done, C_out;
  logic [31:0] out;

  typedef struct {
    logic [31:0] o;
    logic        c;
    int          at;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          vectors = 0;
  int          errors = 0;
  logic [31:0] last_out;
  logic        last_c;

  localparam logic [1:0] M_LSL = 2'b00, M_LSR = 2'b01, M_ASR = 2'b10, M_ROR = 2'b11;

  reg_shift_unit #(.STEP(4)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .Val_Rm(Val_Rm), .Val_Rs(Val_Rs), .shift_mode(shift_mode), .C_in(C_in),
    .busy(busy), .done(done), .out(out), .C_out(C_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.name, "_out"}, out, e.o);
        chk({e.name, "_cout"}, {31'b0, C_out}, {31'b0, e.c});
        chk({e.name, "_latency"}, cyc, e.at);
      end
    end
  end

  // Drives a one-cycle start; returns at the negedge right after the capture edge.
  task automatic launch(input string nm, input logic [1:0] md, input logic [31:0] rm,
                        input logic [31:0] rs, input logic cin, input bit push,
                        input logic [31:0] eo, input logic ec, input int m);
    @(negedge clk);
    Val_Rm = rm; Val_Rs = rs; shift_mode = md; C_in = cin; start = 1'b1;
    if (push) begin
      sbq.push_back('{o: eo, c: ec, at: cyc + 1 + m, name: nm});
      last_out = eo;
      last_c   = ec;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_busy_low"}, {31'b0, busy}, 32'd0);
    chk({nm, "_completed"}, sbq.size(), 32'd0);
  endtask

  task automatic op(input string nm, input logic [1:0] md, input logic [31:0] rm,
                    input logic [31:0] rs, input logic cin,
                    input logic [31:0] eo, input logic ec, input int m);
    launch(nm, md, rm, rs, cin, 1'b1, eo, ec, m);
    wait_idle(nm);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0; C_in = 1'b0;
    Val_Rm = '0; Val_Rs = '0; shift_mode = M_LSL;
    last_out = '0; last_c = 1'b0;
    #12;
    chk("reset_out", out, 32'd0);
    chk("reset_cout", {31'b0, C_out}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    op("lsl_1_by_4",     M_LSL, 32'h0000_0001, 32'd4,     1'b1, 32'h0000_0010, 1'b0, 1);
    op("lsr_by_32",      M_LSR, 32'h8000_0000, 32'd32,    1'b0, 32'h0000_0000, 1'b1, 8);
    op("lsr_by_33",      M_LSR, 32'h8000_0000, 32'd33,    1'b1, 32'h0000_0000, 1'b0, 8);
    op("lsr_rs_0x121",   M_LSR, 32'h8000_0000, 32'h121,   1'b1, 32'h0000_0000, 1'b0, 8);
    op("asr_by_40",      M_ASR, 32'h8000_0000, 32'd40,    1'b0, 32'hFFFF_FFFF, 1'b1, 8);
    op("asr_pos_by_4",   M_ASR, 32'h7FFF_FFF0, 32'd4,     1'b1, 32'h07FF_FFFF, 1'b0, 1);
    op("ror_by_36",      M_ROR, 32'h0000_00F1, 32'd36,    1'b1, 32'h1000_000F, 1'b0, 1);
    op("ror_by_0x20",    M_ROR, 32'h0000_00F1, 32'h20,    1'b1, 32'h0000_00F1, 1'b0, 0);
    op("ror_by_0x40",    M_ROR, 32'h8000_0001, 32'h40,    1'b0, 32'h8000_0001, 1'b1, 0);
    op("amt0_lsl",       M_LSL, 32'h1234_5678, 32'h0,     1'b1, 32'h1234_5678, 1'b1, 0);
    op("amt0_lsr",       M_LSR, 32'h1234_5678, 32'h100,   1'b1, 32'h1234_5678, 1'b1, 0);
    op("amt0_asr",       M_ASR, 32'h1234_5678, 32'h0,     1'b1, 32'h1234_5678, 1'b1, 0);
    op("amt0_ror",       M_ROR, 32'h1234_5678, 32'h0,     1'b1, 32'h1234_5678, 1'b1, 0);
    op("lsl_by_32",      M_LSL, 32'h0000_0001, 32'd32,    1'b0, 32'h0000_0000, 1'b1, 8);
    op("lsl_by_33",      M_LSL, 32'h8000_0001, 32'd33,    1'b1, 32'h0000_0000, 1'b0, 8);
    op("lsl_by_3",       M_LSL, 32'hE000_0000, 32'd3,     1'b0, 32'h0000_0000, 1'b1, 1);
    op("lsr_by_5",       M_LSR, 32'h0000_0030, 32'd5,     1'b0, 32'h0000_0001, 1'b1, 2);
    op("asr_neg_by_7",   M_ASR, 32'hF000_0000, 32'd7,     1'b1, 32'hFFE0_0000, 1'b0, 2);
    op("ror_by_9",       M_ROR, 32'h0000_0181, 32'd9,     1'b0, 32'hC080_0000, 1'b1, 3);

    // flush on the 3rd SHIFT cycle of an LSL by 32
    launch("flush_op", M_LSL, 32'h0000_0003, 32'd32, 1'b0, 1'b0, '0, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    chk("shift_out_stable", out, last_out);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_out_kept", out, last_out);
    chk("flush_cout_kept", {31'b0, C_out}, {31'b0, last_c});
    repeat (10) @(negedge clk);

    // start while busy is ignored, not queued
    launch("busy_start", M_LSR, 32'h8000_0000, 32'd32, 1'b0, 1'b1, 32'h0, 1'b1, 8);
    @(negedge clk);
    Val_Rm = 32'hFFFF_FFFF; Val_Rs = 32'd1; shift_mode = M_LSL; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy_start");
    repeat (12) @(negedge clk);
    chk("no_queued_start", {31'b0, busy}, 32'd0);

    // reset mid-SHIFT
    launch("reset_op", M_LSL, 32'h0000_0001, 32'd32, 1'b0, 1'b0, '0, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out", out, 32'd0);
    chk("midrst_cout", {31'b0, C_out}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    last_out = '0; last_c = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    op("after_reset", M_LSL, 32'h0000_0001, 32'd4, 1'b0, 32'h0000_0010, 1'b0, 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
